vfb_bank_ctrl: RTL and testbench

Parametrised frame-buffer bank controller for the DDR video path. It generalises the fixed two-bit write/read bank switch to NUM_BANKS buffers, runs a per-bank state machine under a newest-complete-frame policy, and generates the burst word addresses for the write and read FIFO controllers. It sits in the phy_clk domain between the DDR controller's burst handshake and the dual-clock FIFO controller, and it reports dropped and repeated frames.

---
 rtl/vfb_pkg.sv | 21 ++
 rtl/vfb_bank_pick.sv | 25 ++
 rtl/vfb_bank_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_vfb_bank_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vfb_pkg.sv
// Shared types and helpers for the frame-buffer bank controller.
// Holds the per-bank state encoding and the burst word-address composition.
package vfb_pkg;

    typedef enum logic [1:0] {
        BANK_FREE    = 2'd0,
        BANK_WRITING = 2'd1,
        BANK_READY   = 2'd2,
        BANK_READING = 2'd3
    } bank_state_t;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // The offset must stay below 2**shift so the bank field is never disturbed.
    function automatic logic [63:0] compose_addr(input logic [7:0]  bank,
                                                 input logic [31:0] offset,
                                                 input int unsigned shift);
        return (64'(bank) << shift) | 64'(offset);
    endfunction

endpackage

// File: rtl/vfb_bank_pick.sv
// Lowest-index priority encoder over the mask of banks the writer may claim.
module vfb_bank_pick
    import vfb_pkg::*;
#(
    parameter int NUM_BANKS = 4,
    parameter int BANK_W    = $clog2(NUM_BANKS)
) (
    input  logic [NUM_BANKS-1:0] free_mask,
    output logic                 found,
    output logic [BANK_W-1:0]    idx
);

    // Scanning downwards leaves the lowest set bit as the final winner.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = NUM_BANKS - 1; i >= 0; i--) begin
            if (free_mask[i]) begin
                found = 1'b1;
                idx   = BANK_W'(i);
            end
        end
    end

endmodule

// File: rtl/vfb_bank_ctrl.sv
// Frame-buffer bank controller: newest-complete-frame policy over NUM_BANKS
// buffers, burst word-address generation and dropped/repeated frame counters.
module vfb_bank_ctrl
    import vfb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 28,
    parameter int NUM_BANKS    = 4,
    parameter int BANK_SHIFT   = 22,
    parameter int FRAME_WORDS  = 49152,
    parameter int WR_BURST_LEN = 64,
    parameter int RD_BURST_LEN = 192,
    parameter int BANK_W       = $clog2(NUM_BANKS)
) (
    input  logic                  phy_clk,
    input  logic                  phy_rst,
    input  logic                  init_calib_complete,
    input  logic                  vin_vs,
    input  logic                  vout_vs,
    input  logic                  wr_burst_finish,
    input  logic                  rd_burst_finish,
    output logic [ADDR_WIDTH-4:0] wr_burst_addr,
    output logic [ADDR_WIDTH-4:0] rd_burst_addr,
    output logic                  wr_en,
    output logic                  rd_valid,
    output logic [BANK_W-1:0]     wr_bank,
    output logic [BANK_W-1:0]     rd_bank,
    output logic [15:0]           frame_dropped,
    output logic [15:0]           frame_repeated
);

    localparam int WA    = ADDR_WIDTH - 3;
    localparam int OFF_W = $clog2(FRAME_WORDS + 1);

    localparam logic [OFF_W-1:0] FRAME_END = OFF_W'(FRAME_WORDS);
    localparam logic [OFF_W:0]   FRAME_EXT = (OFF_W + 1)'(FRAME_WORDS);
    localparam logic [OFF_W:0]   WR_STEP   = (OFF_W + 1)'(WR_BURST_LEN);
    localparam logic [OFF_W:0]   RD_STEP   = (OFF_W + 1)'(RD_BURST_LEN);

    logic vin_q, vin_q2, vout_q, vout_q2;
    logic wr_active;
    logic [OFF_W-1:0] wr_off, rd_off;
    bank_state_t bank_state [NUM_BANKS];

    logic wr_edge, rd_edge, publish;
    logic [NUM_BANKS-1:0] free_mask;
    logic pick_found;
    logic [BANK_W-1:0] pick_idx;

    bank_state_t state_n [NUM_BANKS];
    logic [BANK_W-1:0] wr_bank_n, rd_bank_n, ready_idx;
    logic [OFF_W-1:0] wr_off_n, rd_off_n;
    logic [OFF_W:0] wr_sum, rd_sum;
    logic wr_active_n, rd_valid_n, wr_en_n, ready_found, drop_inc, rep_inc;
    logic [15:0] dropped_n, repeated_n;
    logic [WA-1:0] wr_addr_n, rd_addr_n;

    assign wr_edge = vin_q  & ~vin_q2  & init_calib_complete;
    assign rd_edge = vout_q & ~vout_q2 & init_calib_complete;
    assign publish = wr_edge & wr_active & (wr_off == FRAME_END);

    // An older READY frame is about to be displaced, so the writer may claim it.
    always_comb begin
        for (int i = 0; i < NUM_BANKS; i++) begin
            free_mask[i] = (bank_state[i] == BANK_FREE) ||
                           (publish && bank_state[i] == BANK_READY);
        end
    end

    vfb_bank_pick #(
        .NUM_BANKS (NUM_BANKS),
        .BANK_W    (BANK_W)
    ) u_pick (
        .free_mask (free_mask),
        .found     (pick_found),
        .idx       (pick_idx)
    );

    // Write side resolves before read side so a same-cycle read sees the new frame.
    always_comb begin
        state_n     = bank_state;
        wr_bank_n   = wr_bank;
        rd_bank_n   = rd_bank;
        wr_off_n    = wr_off;
        rd_off_n    = rd_off;
        wr_active_n = wr_active;
        rd_valid_n  = rd_valid;
        drop_inc    = 1'b0;
        rep_inc     = 1'b0;
        ready_found = 1'b0;
        ready_idx   = '0;
        wr_sum      = {1'b0, wr_off} + WR_STEP;
        rd_sum      = {1'b0, rd_off} + RD_STEP;

        if (wr_edge) begin
            wr_active_n = 1'b1;
            wr_off_n    = '0;
            if (publish) begin
                if (pick_found) begin
                    for (int i = 0; i < NUM_BANKS; i++) begin
                        if (state_n[i] == BANK_READY) begin
                            state_n[i] = BANK_FREE;
                            drop_inc   = 1'b1;
                        end
                    end
                    state_n[wr_bank]  = BANK_READY;
                    state_n[pick_idx] = BANK_WRITING;
                    wr_bank_n         = pick_idx;
                end else begin
                    drop_inc = 1'b1;
                end
            end
        end else if (wr_burst_finish && init_calib_complete) begin
            wr_off_n = (wr_sum >= FRAME_EXT) ? FRAME_END : wr_sum[OFF_W-1:0];
        end

        for (int i = 0; i < NUM_BANKS; i++) begin
            if (state_n[i] == BANK_READY) begin
                ready_found = 1'b1;
                ready_idx   = BANK_W'(i);
            end
        end

        if (rd_edge) begin
            rd_off_n = '0;
            if (ready_found) begin
                for (int i = 0; i < NUM_BANKS; i++) begin
                    if (state_n[i] == BANK_READING) begin
                        state_n[i] = BANK_FREE;
                    end
                end
                state_n[ready_idx] = BANK_READING;
                rd_bank_n          = ready_idx;
                rd_valid_n         = 1'b1;
            end else if (rd_valid) begin
                rep_inc = 1'b1;
            end
        end else if (rd_burst_finish && init_calib_complete) begin
            rd_off_n = (rd_sum >= FRAME_EXT) ? '0 : rd_sum[OFF_W-1:0];
        end

        dropped_n  = (drop_inc && frame_dropped  != CNT_MAX) ? frame_dropped  + 16'd1 : frame_dropped;
        repeated_n = (rep_inc  && frame_repeated != CNT_MAX) ? frame_repeated + 16'd1 : frame_repeated;
        wr_en_n    = wr_active_n && (wr_off_n < FRAME_END);
        wr_addr_n  = WA'(compose_addr(8'(wr_bank_n), 32'(wr_off_n), BANK_SHIFT));
        rd_addr_n  = WA'(compose_addr(8'(rd_bank_n), 32'(rd_off_n), BANK_SHIFT));
    end

    always_ff @(posedge phy_clk) begin
        if (phy_rst) begin
            vin_q          <= 1'b0;
            vin_q2         <= 1'b0;
            vout_q         <= 1'b0;
            vout_q2        <= 1'b0;
            wr_active      <= 1'b0;
            wr_off         <= '0;
            rd_off         <= '0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                bank_state[i] <= (i == 0) ? BANK_WRITING : BANK_FREE;
            end
            wr_bank        <= '0;
            rd_bank        <= '0;
            wr_en          <= 1'b0;
            rd_valid       <= 1'b0;
            frame_dropped  <= '0;
            frame_repeated <= '0;
            wr_burst_addr  <= '0;
            rd_burst_addr  <= '0;
        end else begin
            vin_q          <= vin_vs;
            vin_q2         <= vin_q;
            vout_q         <= vout_vs;
            vout_q2        <= vout_q;
            wr_active      <= wr_active_n;
            wr_off         <= wr_off_n;
            rd_off         <= rd_off_n;
            bank_state     <= state_n;
            wr_bank        <= wr_bank_n;
            rd_bank        <= rd_bank_n;
            wr_en          <= wr_en_n;
            rd_valid       <= rd_valid_n;
            frame_dropped  <= dropped_n;
            frame_repeated <= repeated_n;
            wr_burst_addr  <= wr_addr_n;
            rd_burst_addr  <= rd_addr_n;
        end
    end

endmodule

// File: tb/tb_vfb_bank_ctrl.sv
// Directed bench for vfb_bank_ctrl: a four-bank and a two-bank instance share
// one stimulus stream; expected snapshots are queued and checked after latency.
module tb_vfb_bank_ctrl;

    localparam int WA = 25;

    typedef struct {
        string       tag;
        int          sel;
        logic [2:0]  wr_bank;
        logic [2:0]  rd_bank;
        logic [24:0] wr_addr;
        logic [24:0] rd_addr;
        logic        wr_en;
        logic        rd_valid;
        logic [15:0] dropped;
        logic [15:0] repeated;
    } snap_t;

    logic phy_clk = 1'b0;
    logic phy_rst, init_calib_complete, vin_vs, vout_vs, wr_burst_finish, rd_burst_finish;

    logic [WA-1:0] a_wr_addr, a_rd_addr, b_wr_addr, b_rd_addr;
    logic          a_wr_en, a_rd_valid, b_wr_en, b_rd_valid;
    logic [1:0]    a_wr_bank, a_rd_bank;
    logic [0:0]    b_wr_bank, b_rd_bank;
    logic [15:0]   a_dropped, a_repeated, b_dropped, b_repeated;

    snap_t expq[$];
    int compared   = 0;
    int mismatched = 0;

    always #5 phy_clk = ~phy_clk;

    vfb_bank_ctrl #(.NUM_BANKS(4)) dut_a (
        .phy_clk             (phy_clk),
        .phy_rst             (phy_rst),
        .init_calib_complete (init_calib_complete),
        .vin_vs              (vin_vs),
        .vout_vs             (vout_vs),
        .wr_burst_finish     (wr_burst_finish),
        .rd_burst_finish     (rd_burst_finish),
        .wr_burst_addr       (a_wr_addr),
        .rd_burst_addr       (a_rd_addr),
        .wr_en               (a_wr_en),
        .rd_valid            (a_rd_valid),
        .wr_bank             (a_wr_bank),
        .rd_bank             (a_rd_bank),
        .frame_dropped       (a_dropped),
        .frame_repeated      (a_repeated)
    );

    vfb_bank_ctrl #(.NUM_BANKS(2)) dut_b (
        .phy_clk             (phy_clk),
        .phy_rst             (phy_rst),
        .init_calib_complete (init_calib_complete),
        .vin_vs              (vin_vs),
        .vout_vs             (vout_vs),
        .wr_burst_finish     (wr_burst_finish),
        .rd_burst_finish     (rd_burst_finish),
        .wr_burst_addr       (b_wr_addr),
        .rd_burst_addr       (b_rd_addr),
        .wr_en               (b_wr_en),
        .rd_valid            (b_rd_valid),
        .wr_bank             (b_wr_bank),
        .rd_bank             (b_rd_bank),
        .frame_dropped       (b_dropped),
        .frame_repeated      (b_repeated)
    );

    // Called at a negedge; drives the pattern for 'cycles' clocks, then idles the inputs.
    task automatic applyStimulus(input logic vin, input logic vout, input logic wrf,
                                 input logic rdf, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            vin_vs          = vin;
            vout_vs         = vout;
            wr_burst_finish = wrf;
            rd_burst_finish = rdf;
            @(negedge phy_clk);
        end
        vin_vs          = 1'b0;
        vout_vs         = 1'b0;
        wr_burst_finish = 1'b0;
        rd_burst_finish = 1'b0;
    endtask

    task automatic applyReset();
        phy_rst = 1'b1;
        repeat (2) @(negedge phy_clk);
        phy_rst = 1'b0;
    endtask

    task automatic expectSnap(input string tag, input int sel, input logic [2:0] wb,
                              input logic [2:0] rb, input logic [24:0] wa, input logic [24:0] ra,
                              input logic we, input logic rv, input logic [15:0] dr,
                              input logic [15:0] rp);
        snap_t s;
        s.tag = tag; s.sel = sel; s.wr_bank = wb; s.rd_bank = rb; s.wr_addr = wa;
        s.rd_addr = ra; s.wr_en = we; s.rd_valid = rv; s.dropped = dr; s.repeated = rp;
        expq.push_back(s);
    endtask

    task automatic cmpField(input string tag, input string field,
                            input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s.%s observed=0x%0h expected=0x%0h", tag, field, obs, exp);
        end
    endtask

    task automatic checkOutput();
        snap_t s;
        while (expq.size() > 0) begin
            s = expq.pop_front();
            if (s.sel == 0) begin
                cmpField(s.tag, "a.wr_bank",  32'(a_wr_bank),  32'(s.wr_bank));
                cmpField(s.tag, "a.rd_bank",  32'(a_rd_bank),  32'(s.rd_bank));
                cmpField(s.tag, "a.wr_addr",  32'(a_wr_addr),  32'(s.wr_addr));
                cmpField(s.tag, "a.rd_addr",  32'(a_rd_addr),  32'(s.rd_addr));
                cmpField(s.tag, "a.wr_en",    32'(a_wr_en),    32'(s.wr_en));
                cmpField(s.tag, "a.rd_valid", 32'(a_rd_valid), 32'(s.rd_valid));
                cmpField(s.tag, "a.dropped",  32'(a_dropped),  32'(s.dropped));
                cmpField(s.tag, "a.repeated", 32'(a_repeated), 32'(s.repeated));
            end else begin
                cmpField(s.tag, "b.wr_bank",  32'(b_wr_bank),  32'(s.wr_bank));
                cmpField(s.tag, "b.rd_bank",  32'(b_rd_bank),  32'(s.rd_bank));
                cmpField(s.tag, "b.wr_addr",  32'(b_wr_addr),  32'(s.wr_addr));
                cmpField(s.tag, "b.rd_addr",  32'(b_rd_addr),  32'(s.rd_addr));
                cmpField(s.tag, "b.wr_en",    32'(b_wr_en),    32'(s.wr_en));
                cmpField(s.tag, "b.rd_valid", 32'(b_rd_valid), 32'(s.rd_valid));
                cmpField(s.tag, "b.dropped",  32'(b_dropped),  32'(s.dropped));
                cmpField(s.tag, "b.repeated", 32'(b_repeated), 32'(s.repeated));
            end
        end
    endtask

    task automatic expectIdle(input string tag);
        expectSnap(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expectSnap(tag, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog expired before the sequence completed");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        phy_rst = 1'b1; init_calib_complete = 1'b0;
        vin_vs = 1'b0; vout_vs = 1'b0; wr_burst_finish = 1'b0; rd_burst_finish = 1'b0;
        repeat (3) @(negedge phy_clk);
        phy_rst = 1'b0;
        @(negedge phy_clk);
        expectIdle("reset");
        checkOutput();

        // Calibration still low: edges and bursts must be ignored.
        expectIdle("no_init");
        applyStimulus(1, 0, 0, 0, 1);
        @(negedge phy_clk);
        applyStimulus(0, 0, 1, 0, 3);
        checkOutput();

        init_calib_complete = 1'b1;
        @(negedge phy_clk);
        expectSnap("first_vin", 0, 0, 0, 0, 0, 1, 0, 0, 0);
        expectSnap("first_vin", 1, 0, 0, 0, 0, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 1);
        @(negedge phy_clk);
        checkOutput();

        expectSnap("wr640", 0, 0, 0, 25'd640, 0, 1, 0, 0, 0);
        expectSnap("wr640", 1, 0, 0, 25'd640, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 10);
        checkOutput();

        expectIdle("rst_mid");
        applyReset();
        checkOutput();

        expectIdle("vout_after_rst");
        applyStimulus(0, 1, 0, 0, 1);
        @(negedge phy_clk);
        checkOutput();

        expectSnap("vin2", 0, 0, 0, 0, 0, 1, 0, 0, 0);
        expectSnap("vin2", 1, 0, 0, 0, 0, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 1);
        @(negedge phy_clk);
        checkOutput();

        expectSnap("wr767", 0, 0, 0, 25'd49088, 0, 1, 0, 0, 0);
        expectSnap("wr767", 1, 0, 0, 25'd49088, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 767);
        checkOutput();

        expectSnap("wr_sat", 0, 0, 0, 25'd49152, 0, 0, 0, 0, 0);
        expectSnap("wr_sat", 1, 0, 0, 25'd49152, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 2);
        checkOutput();

        // Simultaneous edges: reader takes the bank published in the same cycle.
        expectSnap("pub_read", 0, 1, 0, 25'h400000, 0, 1, 1, 0, 0);
        expectSnap("pub_read", 1, 1, 0, 25'h400000, 0, 1, 1, 0, 0);
        applyStimulus(1, 1, 0, 0, 1);
        @(negedge phy_clk);
        checkOutput();

        // Two-bank instance has no free bank while the reader holds bank 0.
        expectSnap("pub_b1", 0, 2, 0, 25'h800000, 0, 1, 1, 0, 0);
        expectSnap("pub_b1", 1, 1, 0, 25'h400000, 0, 1, 1, 1, 0);
        applyStimulus(0, 0, 1, 0, 768);
        applyStimulus(1, 0, 0, 0, 1);
        @(negedge phy_clk);
        checkOutput();

        expectSnap("drop_old", 0, 1, 0, 25'h400000, 0, 1, 1, 1, 0);
        expectSnap("drop_old", 1, 1, 0, 25'h400000, 0, 1, 1, 2, 0);
        applyStimulus(0, 0, 1, 0, 768);
        applyStimulus(1, 0, 0, 0, 1);
        @(negedge phy_clk);
        checkOutput();

        expectSnap("take_ready", 0, 1, 2, 25'h400000, 25'h800000, 1, 1, 1, 0);
        expectSnap("take_ready", 1, 1, 0, 25'h400000, 0, 1, 1, 2, 1);
        applyStimulus(0, 1, 0, 0, 1);
        @(negedge phy_clk);
        checkOutput();

        expectSnap("rd960", 0, 1, 2, 25'h400000, 25'h8003C0, 1, 1, 1, 0);
        expectSnap("rd960", 1, 1, 0, 25'h400000, 25'h0003C0, 1, 1, 2, 1);
        applyStimulus(0, 0, 0, 1, 5);
        checkOutput();

        expectSnap("repeat1", 0, 1, 2, 25'h400000, 25'h800000, 1, 1, 1, 1);
        expectSnap("repeat1", 1, 1, 0, 25'h400000, 0, 1, 1, 2, 2);
        applyStimulus(0, 1, 0, 0, 1);
        @(negedge phy_clk);
        checkOutput();

        // A read burst landing in the edge's update cycle is discarded.
        expectSnap("repeat_discard", 0, 1, 2, 25'h400000, 25'h800000, 1, 1, 1, 2);
        expectSnap("repeat_discard", 1, 1, 0, 25'h400000, 0, 1, 1, 2, 3);
        applyStimulus(0, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput();

        expectSnap("rd255", 0, 1, 2, 25'h400000, 25'h80BF40, 1, 1, 1, 2);
        expectSnap("rd255", 1, 1, 0, 25'h400000, 25'h00BF40, 1, 1, 2, 3);
        applyStimulus(0, 0, 0, 1, 255);
        checkOutput();

        expectSnap("rd_wrap", 0, 1, 2, 25'h400000, 25'h800000, 1, 1, 1, 2);
        expectSnap("rd_wrap", 1, 1, 0, 25'h400000, 0, 1, 1, 2, 3);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput();

        expectSnap("pub_again", 0, 0, 2, 0, 25'h800000, 1, 1, 1, 2);
        expectSnap("pub_again", 1, 1, 0, 25'h400000, 0, 1, 1, 3, 3);
        applyStimulus(0, 0, 1, 0, 768);
        applyStimulus(1, 0, 0, 0, 1);
        @(negedge phy_clk);
        checkOutput();

        expectSnap("wr640b", 0, 0, 2, 25'd640, 25'h800000, 1, 1, 1, 2);
        expectSnap("wr640b", 1, 1, 0, 25'h400280, 0, 1, 1, 3, 3);
        applyStimulus(0, 0, 1, 0, 10);
        checkOutput();

        // Reset with a READY frame pending: it must not survive to the reader.
        expectIdle("rst2");
        applyReset();
        checkOutput();

        expectIdle("no_ready_after_rst");
        applyStimulus(0, 1, 0, 0, 1);
        @(negedge phy_clk);
        checkOutput();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
